// File: rtl/adder_slice_sched.sv
// rtl/adder_slice_sched.sv - shares one 3-bit adder slice between two requesters, WIDTH-bit add LSB-first
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_* / req1_*               job request: valid/ready handshake, operands a/b, carry-in cin
//   sl_a, sl_b, sl_cin            drive the external 3-bit slice for the current step
//   sl_sum, sl_cout               combinational slice result
//   rsp_valid/rsp_ready           result handshake
//   rsp_sum, rsp_cout, rsp_id     result sum, final carry-out, owning requester
module adder_slice_sched #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [2:0]       sl_a,
  output logic [2:0]       sl_b,
  output logic             sl_cin,
  input  logic [2:0]       sl_sum,
  input  logic             sl_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int NSTEP = WIDTH / 3;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [SW-1:0]    step;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             last_step;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign last_step  = (step == SW'(NSTEP - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slice operands select the 3-bit group of the current step; quiet outside RUN.
  always_comb begin
    sl_a   = 3'b000;
    sl_b   = 3'b000;
    sl_cin = 1'b0;
    if (state == RUN) begin
      sl_cin = carry;
      for (int k = 0; k < NSTEP; k++) begin
        if (step == SW'(k)) begin
          sl_a = op_a[3*k +: 3];
          sl_b = op_b[3*k +: 3];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      carry      <= 1'b0;
      step       <= '0;
      last_grant <= 1'b1;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant ? req1_a   : req0_a;
            op_b       <= grant ? req1_b   : req0_b;
            carry      <= grant ? req1_cin : req0_cin;
            step       <= '0;
            last_grant <= grant;
            rsp_id     <= grant;
          end
        end
        RUN: begin
          // The slice result is taken as-is so an approximate slice's errors pass through.
          for (int k = 0; k < NSTEP; k++) begin
            if (step == SW'(k)) begin
              rsp_sum[3*k +: 3] <= sl_sum;
            end
          end
          carry <= sl_cout;
          step  <= step + SW'(1);
          if (last_step) begin
            rsp_cout <= sl_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
